// File: rtl/item_query_display.sv
// item_query_display: query-mode 7-seg display (price, stock, letter, item number), auto-cycling with manual hold.
// Optional feature: define LOW_STOCK_BLINK_EN for low-stock blinking and '-' on empty stock.
module item_query_display #(
    parameter int ITEM_NUM     = 4,
    parameter int VAL_W        = 8,
    parameter int SCAN_CYCLES  = 100_000,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int HOLD_CYCLES  = 300_000_000
`ifdef LOW_STOCK_BLINK_EN
    ,
    parameter int LOW_THRESH   = 3,
    parameter int BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [ITEM_NUM-1:0]       sel,
    input  logic [ITEM_NUM*VAL_W-1:0] price_bus,
    input  logic [ITEM_NUM*VAL_W-1:0] stock_bus,
    output logic [7:0]                DIG,
    output logic [7:0]                Y,
    output logic [2:0]                cur_item,
    output logic                      held
);
    localparam int SCAN_W  = $clog2(SCAN_CYCLES + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {ST_AUTO, ST_HOLD, ST_OFF} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cur_q, cur_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SCAN_W-1:0]  scan_cnt_q;
    logic [2:0]         scan_idx_q;
    logic [7:0]         dig_q, dig_d, y_q, y_d;
    logic [3:0]         sel_hits;
    logic [2:0]         sel_item;
    logic               sel_ok;
    logic [VAL_W-1:0]   price_v, stock_v;
    logic [7:0]         pbcd, sbcd;

    // Two BCD digits {tens, ones}; anything above 99 saturates to 99.
    function automatic logic [7:0] to_bcd(input logic [VAL_W-1:0] v);
        logic [6:0] t;
        if (32'(v) > 99) return 8'h99;
        t = 7'(v);
        return {4'(t / 7'd10), 4'(t % 7'd10)};
    endfunction

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] seg_letter(input logic [2:0] item);
        case (item)
            3'd1: return 8'h88;
            3'd2: return 8'h83;
            3'd3: return 8'hC6;
            3'd4: return 8'hA1;
            3'd5: return 8'h86;
            3'd6: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    // After the last item comes one blank slot (0) before wrapping to item 1.
    function automatic logic [2:0] next_item(input logic [2:0] c);
        return (c == 3'(ITEM_NUM)) ? 3'd0 : c + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_q <= '0;
            scan_idx_q <= scan_idx_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    always_comb begin
        sel_hits = '0;
        sel_item = '0;
        for (int k = 0; k < ITEM_NUM; k++) begin
            if (sel[k]) begin
                sel_hits = sel_hits + 4'd1;
                sel_item = 3'(k + 1);
            end
        end
        sel_ok = en && (sel_hits == 4'd1);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        hold_d  = hold_q;
        if (!en) begin
            state_d = ST_OFF;
            cur_d   = 3'd0;
            dwell_d = '0;
            hold_d  = '0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_AUTO;
            cur_d   = 3'd1;
            dwell_d = '0;
        end else if (sel_ok) begin
            state_d = ST_HOLD;
            cur_d   = sel_item;
            dwell_d = '0;
            hold_d  = '0;
        end else if (state_q == ST_AUTO) begin
            if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                dwell_d = '0;
                cur_d   = next_item(cur_q);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                state_d = ST_AUTO;
                hold_d  = '0;
                dwell_d = '0;
                cur_d   = next_item(cur_q);
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_AUTO;
            cur_q   <= 3'd1;
            dwell_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            hold_q  <= hold_d;
        end
    end

`ifdef LOW_STOCK_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;

    // blink_q high is the off-phase for low-stock digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        price_v = '0;
        stock_v = '0;
        for (int k = 0; k < ITEM_NUM; k++) begin
            if (cur_q == 3'(k + 1)) begin
                price_v = price_bus[k*VAL_W +: VAL_W];
                stock_v = stock_bus[k*VAL_W +: VAL_W];
            end
        end
        pbcd  = to_bcd(price_v);
        sbcd  = to_bcd(stock_v);
        dig_d = (scan_idx_q == 3'd4 || scan_idx_q == 3'd6) ? 8'hFF : ~(8'd1 << scan_idx_q);
        case (scan_idx_q)
            3'd0: y_d = seg_digit(pbcd[3:0]);
            3'd1: y_d = seg_digit(pbcd[7:4]);
            3'd2: y_d = seg_digit(sbcd[3:0]);
            3'd3: y_d = seg_digit(sbcd[7:4]);
            3'd5: y_d = seg_letter(cur_q);
            3'd7: y_d = seg_digit({1'b0, cur_q});
            default: y_d = 8'hFF;
        endcase
`ifdef LOW_STOCK_BLINK_EN
        if (scan_idx_q == 3'd2 || scan_idx_q == 3'd3) begin
            if (stock_v == '0) y_d = 8'hBF;
            else if (32'(stock_v) < LOW_THRESH && blink_q) y_d = 8'hFF;
        end
`endif
        if (!en || cur_q == 3'd0) y_d = 8'hFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_q <= 8'hFF;
            y_q   <= 8'hFF;
        end else begin
            dig_q <= dig_d;
            y_q   <= y_d;
        end
    end

    assign DIG      = dig_q;
    assign Y        = y_q;
    assign cur_item = cur_q;
    assign held     = (state_q == ST_HOLD);
endmodule

// File: tb/tb_item_query_display.sv
// Directed bench for item_query_display: auto cycling, scan/segment tables, hold, enable and reset behaviour.
module tb_item_query_display;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  sel;
    logic [31:0] price_bus;
    logic [31:0] stock_bus;
    logic [7:0]  DIG;
    logic [7:0]  Y;
    logic [2:0]  cur_item;
    logic        held;

    int checks = 0;
    int errors = 0;
    int n = 0;

    item_query_display #(
        .ITEM_NUM(4), .VAL_W(8), .SCAN_CYCLES(2), .DWELL_CYCLES(16), .HOLD_CYCLES(40)
`ifdef LOW_STOCK_BLINK_EN
        , .LOW_THRESH(6), .BLINK_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .price_bus(price_bus), .stock_bus(stock_bus),
        .DIG(DIG), .Y(Y), .cur_item(cur_item), .held(held)
    );

    always #5 clk = ~clk;

    // Hand-computed segment patterns per shown item (0 = blank) and scan index.
    logic [7:0] ytab [5][8] = '{
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'h99, 8'hC0, 8'hC0, 8'hF9, 8'hFF, 8'h88, 8'hFF, 8'hF9},
        '{8'h90, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'h83, 8'hFF, 8'hA4},
        '{8'hB0, 8'hF9, 8'h92, 8'hC0, 8'hFF, 8'hC6, 8'hFF, 8'hB0},
        '{8'hF8, 8'hF9, 8'h90, 8'h90, 8'hFF, 8'hA1, 8'hFF, 8'h99}
    };
    logic [7:0] digtab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hDF, 8'hFF, 8'h7F};
    logic [2:0] seqtab [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    initial begin
        int m;
        int ix;
        logic [2:0] it;
        logic [7:0] ey;
`ifdef LOW_STOCK_BLINK_EN
        ytab[2][2] = 8'hBF;
        ytab[2][3] = 8'hBF;
`endif
        rst       = 1'b0;
        en        = 1'b1;
        sel       = 4'b0000;
        price_bus = {8'd17, 8'd13, 8'd9, 8'd4};
        stock_bus = {8'd120, 8'd5, 8'd0, 8'd10};
        repeat (2) @(negedge clk);
        check("rst_dig", DIG, 8'hFF);
        check("rst_y", Y, 8'hFF);
        check("rst_cur", 8'(cur_item), 8'd1);
        check("rst_held", 8'(held), 8'd0);
        rst = 1'b1;

        // Auto cycling with full scan: outputs after posedge n reflect state after posedge n-1.
        for (int k = 0; k < 80; k++) begin
            step();
            m  = n - 1;
            ix = (m / 2) % 8;
            it = seqtab[(m / 16) % 5];
            ey = ytab[it][ix];
`ifdef LOW_STOCK_BLINK_EN
            if (it == 3'd3 && (ix == 2 || ix == 3) && ((m / 4) % 2) == 1) ey = 8'hFF;
`endif
            check($sformatf("auto_cur%0d", n), 8'(cur_item), 8'(seqtab[(n / 16) % 5]));
            check($sformatf("auto_dig%0d", n), DIG, digtab[ix]);
            check($sformatf("auto_y%0d", n), Y, ey);
        end
        check("auto_held", 8'(held), 8'd0);

        run_to(130);
        check("pre_sel_cur", 8'(cur_item), 8'd4);
        sel = 4'b0010;
        step();
        sel = 4'b0000;
        check("sel_cur", 8'(cur_item), 8'd2);
        check("sel_held", 8'(held), 8'd1);
        run_to(170);
        check("hold_end_cur", 8'(cur_item), 8'd2);
        check("hold_end_held", 8'(held), 8'd1);
        step();
        check("hold_exit_cur", 8'(cur_item), 8'd3);
        check("hold_exit_held", 8'(held), 8'd0);
        run_to(186);
        check("dwell_restart_cur", 8'(cur_item), 8'd3);
        step();
        check("dwell_next_cur", 8'(cur_item), 8'd4);

        sel = 4'b0110;
        step();
        sel = 4'b0000;
        check("multi_sel_cur", 8'(cur_item), 8'd4);
        check("multi_sel_held", 8'(held), 8'd0);

        en = 1'b0;
        step();
        check("off_cur", 8'(cur_item), 8'd0);
        check("off_y", Y, 8'hFF);
        check("off_held", 8'(held), 8'd0);
        sel = 4'b0001;
        step();
        sel = 4'b0000;
        check("off_sel_cur", 8'(cur_item), 8'd0);
        check("off_sel_held", 8'(held), 8'd0);
        while (n < 194) begin
            step();
            check($sformatf("off_y%0d", n), Y, 8'hFF);
        end
        en = 1'b1;
        step();
        check("on_cur", 8'(cur_item), 8'd1);
        check("on_held", 8'(held), 8'd0);
        run_to(210);
        check("on_dwell_cur", 8'(cur_item), 8'd1);
        step();
        check("on_next_cur", 8'(cur_item), 8'd2);

        en  = 1'b0;
        sel = 4'b1000;
        step();
        sel = 4'b0000;
        check("off_wins_cur", 8'(cur_item), 8'd0);
        check("off_wins_held", 8'(held), 8'd0);
        en = 1'b1;
        step();
        check("reon_cur", 8'(cur_item), 8'd1);

        sel = 4'b0100;
        step();
        sel = 4'b0000;
        check("hold3_cur", 8'(cur_item), 8'd3);
        check("hold3_held", 8'(held), 8'd1);
        run_to(217);
        #2 rst = 1'b0;
        #1;
        check("async_cur", 8'(cur_item), 8'd1);
        check("async_held", 8'(held), 8'd0);
        check("async_dig", DIG, 8'hFF);
        check("async_y", Y, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
